id_ex_stage: RTL and testbench

- ID/EX pipeline register plus EX-side operand selection for the five-stage MIPS pipeline.
- Captures decoded operands and control from ID, detects load-use hazards, and applies MEM/WB forwarding.
- Drives input1/input2/aluCtr of the ALU directly, and passes its control bits and store data on toward EX/MEM.

---
 rtl/id_ex_stage_pkg.sv | 14 +
 rtl/id_ex_stage_fwd_mux.sv | 29 ++
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared ALU opcodes and register constants for the ID/EX stage
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = ALU_ADD;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - single-operand MEM/WB forwarding selector
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] stored,
    input  logic              mem_regWrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] value
);

    // $0 is never forwarded; the younger MEM producer beats WB.
    always_comb begin
        value = stored;
        if (idx != '0) begin
            if (mem_regWrite && (mem_rd == idx)) begin
                value = mem_result;
            end else if (wb_regWrite && (wb_rd == idx)) begin
                value = wb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX register with load-use stall, capture bypass and EX forwarding
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rt,
    input  logic [3:0]        id_aluCtr,
    input  logic              id_aluSrc,
    input  logic              id_regDst,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              id_memWrite,
    input  logic              id_memToReg,
    input  logic              flush,
    input  logic              mem_regWrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic              stall,
    output logic [DATA_W-1:0] ex_input1,
    output logic [DATA_W-1:0] ex_input2,
    output logic [3:0]        ex_aluCtr,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_writeReg,
    output logic              ex_valid,
    output logic              ex_regWrite,
    output logic              ex_memRead,
    output logic              ex_memWrite,
    output logic              ex_memToReg
);

    logic              ex_aluSrc;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [DATA_W-1:0] ex_rs_val;
    logic [DATA_W-1:0] ex_rt_val;
    logic [DATA_W-1:0] ex_imm;
    logic [15:0]       stall_cnt;

    logic              hazard;
    logic [DATA_W-1:0] rs_cap;
    logic [DATA_W-1:0] rt_cap;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    assign hazard = ex_valid && ex_memRead && id_valid && (ex_rt != REG_AW'(REG_ZERO)) &&
                    ((ex_rt == id_rs) || (id_use_rt && (ex_rt == id_rt)));
    assign stall  = hazard && !flush;

    // WB writes the register file in this same cycle, so the ID read data is stale.
    assign rs_cap = (wb_regWrite && (wb_rd != '0) && (wb_rd == id_rs)) ? wb_result : id_rs_data;
    assign rt_cap = (wb_regWrite && (wb_rd != '0) && (wb_rd == id_rt)) ? wb_result : id_rt_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_regWrite <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_memToReg <= 1'b0;
            ex_aluSrc   <= 1'b0;
            ex_aluCtr   <= ALU_NOP;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_writeReg <= '0;
            ex_rs_val   <= '0;
            ex_rt_val   <= '0;
            ex_imm      <= '0;
            stall_cnt   <= '0;
        end else begin
            if (flush || stall) begin
                ex_valid    <= 1'b0;
                ex_regWrite <= 1'b0;
                ex_memRead  <= 1'b0;
                ex_memWrite <= 1'b0;
                ex_memToReg <= 1'b0;
                ex_aluSrc   <= 1'b0;
                ex_aluCtr   <= ALU_NOP;
                ex_rs       <= '0;
                ex_rt       <= '0;
                ex_writeReg <= '0;
                ex_rs_val   <= '0;
                ex_rt_val   <= '0;
                ex_imm      <= '0;
            end else begin
                ex_valid    <= id_valid;
                ex_regWrite <= id_valid && id_regWrite;
                ex_memRead  <= id_valid && id_memRead;
                ex_memWrite <= id_valid && id_memWrite;
                ex_memToReg <= id_valid && id_memToReg;
                ex_aluSrc   <= id_valid && id_aluSrc;
                ex_aluCtr   <= id_aluCtr;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_writeReg <= id_regDst ? id_rd : id_rt;
                ex_rs_val   <= rs_cap;
                ex_rt_val   <= rt_cap;
                ex_imm      <= id_imm;
            end
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .idx          (ex_rs),
        .stored       (ex_rs_val),
        .mem_regWrite (mem_regWrite),
        .mem_rd       (mem_rd),
        .mem_result   (mem_result),
        .wb_regWrite  (wb_regWrite),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .value        (fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .idx          (ex_rt),
        .stored       (ex_rt_val),
        .mem_regWrite (mem_regWrite),
        .mem_rd       (mem_rd),
        .mem_result   (mem_result),
        .wb_regWrite  (wb_regWrite),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .value        (fwd_rt)
    );

    assign ex_input1     = fwd_rs;
    assign ex_input2     = ex_aluSrc ? ex_imm : fwd_rt;
    assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_use_rt;
    logic [3:0]  id_aluCtr;
    logic        id_aluSrc, id_regDst, id_regWrite, id_memRead, id_memWrite, id_memToReg;
    logic        flush;
    logic        mem_regWrite;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_regWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        stall;
    logic [31:0] ex_input1, ex_input2, ex_store_data;
    logic [3:0]  ex_aluCtr;
    logic [4:0]  ex_writeReg;
    logic        ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg;

    int n_pass  = 0;
    int n_total = 0;
    int cnt_base = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_use_rt(id_use_rt),
        .id_aluCtr(id_aluCtr), .id_aluSrc(id_aluSrc), .id_regDst(id_regDst),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .id_memToReg(id_memToReg), .flush(flush),
        .mem_regWrite(mem_regWrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .stall(stall), .ex_input1(ex_input1), .ex_input2(ex_input2),
        .ex_aluCtr(ex_aluCtr), .ex_store_data(ex_store_data), .ex_writeReg(ex_writeReg),
        .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg)
    );

    always #5 clk = ~clk;

    // Reference: what instruction sits in EX, as plain fields.
    logic        m_valid, m_regWrite, m_memRead, m_memWrite, m_memToReg, m_aluSrc;
    logic [3:0]  m_aluCtr;
    logic [4:0]  m_rs, m_rt, m_dest;
    logic [31:0] m_rs_val, m_rt_val, m_imm;
    int          m_stalls;

    function automatic logic exp_stall();
        logic dep;
        dep = (m_rt == id_rs) || (id_use_rt && m_rt == id_rt);
        return m_valid && m_memRead && id_valid && (m_rt != 0) && dep && !flush;
    endfunction

    function automatic logic [31:0] reg_read(input logic [4:0] idx, input logic [31:0] rf);
        if (wb_regWrite && wb_rd != 0 && wb_rd == idx) return wb_result;
        return rf;
    endfunction

    function automatic logic [31:0] src_value(input logic [4:0] idx, input logic [31:0] stored);
        if (idx == 0) return stored;
        if (mem_regWrite && mem_rd == idx) return mem_result;
        if (wb_regWrite && wb_rd == idx) return wb_result;
        return stored;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 0; m_regWrite <= 0; m_memRead <= 0; m_memWrite <= 0;
            m_memToReg <= 0; m_aluSrc <= 0; m_aluCtr <= 4'b0010;
            m_rs <= 0; m_rt <= 0; m_dest <= 0; m_rs_val <= 0; m_rt_val <= 0; m_imm <= 0;
            m_stalls <= 0;
        end else if (flush || exp_stall()) begin
            m_valid <= 0; m_regWrite <= 0; m_memRead <= 0; m_memWrite <= 0;
            m_memToReg <= 0; m_aluSrc <= 0; m_aluCtr <= 4'b0010;
            m_rs <= 0; m_rt <= 0; m_dest <= 0; m_rs_val <= 0; m_rt_val <= 0; m_imm <= 0;
            if (!flush) m_stalls <= m_stalls + 1;
        end else begin
            m_valid    <= id_valid;
            m_regWrite <= id_valid & id_regWrite;
            m_memRead  <= id_valid & id_memRead;
            m_memWrite <= id_valid & id_memWrite;
            m_memToReg <= id_valid & id_memToReg;
            m_aluSrc   <= id_valid & id_aluSrc;
            m_aluCtr   <= id_aluCtr;
            m_rs <= id_rs; m_rt <= id_rt;
            m_dest     <= id_regDst ? id_rd : id_rt;
            m_rs_val   <= reg_read(id_rs, id_rs_data);
            m_rt_val   <= reg_read(id_rt, id_rt_data);
            m_imm      <= id_imm;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            int e_cnt;
            e_cnt = cnt_base + m_stalls;
            if (e_cnt > 65535) e_cnt = 65535;
            chk("m_stall", {31'd0, stall}, {31'd0, exp_stall()});
            chk("m_valid", {31'd0, ex_valid}, {31'd0, m_valid});
            chk("m_ctrl", {28'd0, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg},
                {28'd0, m_regWrite, m_memRead, m_memWrite, m_memToReg});
            chk("m_aluCtr", {28'd0, ex_aluCtr}, {28'd0, m_aluCtr});
            chk("m_stall_cnt", {16'd0, dut.stall_cnt}, e_cnt[31:0]);
            if (m_valid) begin
                chk("m_input1", ex_input1, src_value(m_rs, m_rs_val));
                chk("m_input2", ex_input2, m_aluSrc ? m_imm : src_value(m_rt, m_rt_val));
                chk("m_store", ex_store_data, src_value(m_rt, m_rt_val));
                chk("m_writeReg", {27'd0, ex_writeReg}, {27'd0, m_dest});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_use_rt = 0; id_aluCtr = 4'b0010;
        {id_aluSrc, id_regDst, id_regWrite, id_memRead, id_memWrite, id_memToReg} = 6'b0;
        flush = 0;
        mem_regWrite = 0; mem_rd = 0; mem_result = 0;
        wb_regWrite = 0; wb_rd = 0; wb_result = 0;
    endtask

    // flags = {aluSrc, regDst, regWrite, memRead, memWrite, memToReg}
    task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic use_rt, input logic [31:0] rs_d, input logic [31:0] rt_d,
                         input logic [31:0] imm, input logic [3:0] ctr, input logic [5:0] flags);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_use_rt = use_rt;
        id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm; id_aluCtr = ctr;
        {id_aluSrc, id_regDst, id_regWrite, id_memRead, id_memWrite, id_memToReg} = flags;
    endtask

    initial begin
        reset = 0;
        idle();
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_aluCtr", {28'd0, ex_aluCtr}, 32'h2);
        chk("rst_in1", ex_input1, 32'd0);
        chk("rst_in2", ex_input2, 32'd0);
        chk("rst_wreg", {27'd0, ex_writeReg}, 32'd0);
        reset = 1;

        // add $3,$1,$2 captured, then async reset mid-cycle
        tick();
        instr(5'd1, 5'd2, 5'd3, 1, 32'h5, 32'h6, 32'h0, 4'b0010, 6'b011000);
        tick();
        chk("cap_valid", {31'd0, ex_valid}, 32'd1);
        chk("cap_regWrite", {31'd0, ex_regWrite}, 32'd1);
        #2 reset = 0;
        #1;
        chk("async_valid", {31'd0, ex_valid}, 32'd0);
        chk("async_regWrite", {31'd0, ex_regWrite}, 32'd0);
        chk("async_aluCtr", {28'd0, ex_aluCtr}, 32'h2);
        chk("async_stall", {31'd0, stall}, 32'd0);
        idle();
        #1 reset = 1;
        tick();

        // lw $2,4($1) then add $3,$2,$4: one bubble
        instr(5'd1, 5'd2, 5'd0, 0, 32'h40, 32'h0, 32'h4, 4'b0010, 6'b101101);
        tick();
        instr(5'd2, 5'd4, 5'd3, 1, 32'h0, 32'h5, 32'h0, 4'b0010, 6'b011000);
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_regWrite", {31'd0, ex_regWrite}, 32'd0);
        chk("lu_stall_drop", {31'd0, stall}, 32'd0);
        chk("lu_cnt", {16'd0, dut.stall_cnt}, 32'd1);
        tick();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_wreg", {27'd0, ex_writeReg}, 32'd3);

        // rs=$5 stored 7: MEM beats WB, then WB alone
        idle();
        instr(5'd5, 5'd9, 5'd10, 0, 32'h7, 32'h0, 32'h0, 4'b0010, 6'b011000);
        tick();
        idle();
        mem_regWrite = 1; mem_rd = 5; mem_result = 32'h10;
        wb_regWrite = 1; wb_rd = 5; wb_result = 32'h20;
        #1;
        chk("fwd_mem_prio", ex_input1, 32'h10);
        mem_regWrite = 0;
        #1;
        chk("fwd_wb", ex_input1, 32'h20);
        wb_regWrite = 0;
        #1;
        chk("fwd_none", ex_input1, 32'h7);
        tick();

        // $0 source ignores forwarding
        instr(5'd0, 5'd0, 5'd7, 0, 32'h0, 32'h0, 32'h0, 4'b0010, 6'b011000);
        tick();
        idle();
        mem_regWrite = 1; mem_rd = 0; mem_result = 32'hFFFF;
        #1;
        chk("fwd_zero", ex_input1, 32'd0);
        tick();
        idle();

        // sw $6,8($1): imm to ALU, WB-forwarded rt to store data
        instr(5'd1, 5'd6, 5'd0, 1, 32'h100, 32'h11, 32'h8, 4'b0010, 6'b100010);
        tick();
        idle();
        wb_regWrite = 1; wb_rd = 6; wb_result = 32'hAB;
        #1;
        chk("sw_in2", ex_input2, 32'h8);
        chk("sw_store", ex_store_data, 32'hAB);
        tick();

        // capture-time WB bypass on rt
        instr(5'd1, 5'd6, 5'd0, 1, 32'h100, 32'h11, 32'h8, 4'b0010, 6'b100010);
        wb_regWrite = 1; wb_rd = 6; wb_result = 32'hCD;
        tick();
        wb_regWrite = 0;
        id_valid = 0;
        #1;
        chk("cap_bypass", ex_store_data, 32'hCD);
        tick();

        // hazard and flush together: flush wins, no stall counted
        instr(5'd1, 5'd2, 5'd0, 0, 32'h40, 32'h0, 32'h4, 4'b0010, 6'b101101);
        tick();
        instr(5'd2, 5'd4, 5'd3, 1, 32'h0, 32'h5, 32'h0, 4'b0010, 6'b011000);
        flush = 1;
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_cnt", {16'd0, dut.stall_cnt}, 32'd1);
        flush = 0;
        tick();
        chk("post_flush_valid", {31'd0, ex_valid}, 32'd1);
        id_valid = 0; flush = 1;
        tick();
        chk("flush_invalid", {31'd0, ex_valid}, 32'd0);
        chk("flush_invalid_rw", {31'd0, ex_regWrite}, 32'd0);
        idle();
        tick();

        // saturation: preload near the top, then alternate lw $2,0($2) hazards
        force dut.stall_cnt = 16'hFFFC;
        cnt_base = 32'hFFFC - m_stalls;
        #2;
        release dut.stall_cnt;
        #1;
        chk("sat_preload", {16'd0, dut.stall_cnt}, 32'hFFFC);
        instr(5'd2, 5'd2, 5'd0, 0, 32'h0, 32'h0, 32'h0, 4'b0010, 6'b101101);
        for (int i = 0; i < 12; i++) tick();
        chk("sat_cnt", {16'd0, dut.stall_cnt}, 32'hFFFF);
        idle();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
